// File: rtl/mips_pkg.sv
// Shared MIPS front-end types: address type, PC sequencer states, default vectors.
package mips_pkg;

    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } pc_seq_state_t;

    localparam addr_t DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
    localparam addr_t DEFAULT_HALT_ADDR    = 32'h0000_0000;

endpackage

// File: rtl/pc_redirect_reg.sv
// Pending redirect target for the delay slot, with the halt compare done at load time.
module pc_redirect_reg
    import mips_pkg::*;
#(
    parameter addr_t HALT_ADDR = DEFAULT_HALT_ADDR
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  addr_t target,
    output addr_t tgt,
    output logic  tgt_halt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            tgt      <= '0;
            tgt_halt <= 1'b0;
        end else if (load) begin
            tgt      <= target;
            tgt_halt <= (target == HALT_ADDR);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential advance, one-delay-slot redirect, stall and halt.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter addr_t RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter addr_t HALT_ADDR    = DEFAULT_HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic        fetch_en,
    output logic        delay_slot,
    output logic        active,
    output logic        seq_err,
    output logic [31:0] instr_count,
    output logic [31:0] br_count
);

    pc_seq_state_t state;
    addr_t         tgt;
    logic          tgt_halt;
    logic          advance;
    logic          taken;
    logic          accept;

    assign advance = (state != HALTED) && !stall;
    assign taken   = br_valid && br_taken;
    assign accept  = advance && (state == RUN) && taken;

    pc_redirect_reg #(.HALT_ADDR(HALT_ADDR)) u_redirect (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .target   ({br_target[31:2], 2'b00}),
        .tgt      (tgt),
        .tgt_halt (tgt_halt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pc      <= RESET_VECTOR;
            seq_err <= 1'b0;
        end else if (advance) begin
            case (state)
                RUN: begin
                    pc <= pc + 32'd4;
                    if (taken) begin
                        state <= DELAY;
                        if (br_target[1:0] != 2'b00)
                            seq_err <= 1'b1;
                    end
                end
                DELAY: begin
                    // A branch sitting in the delay slot cannot be honoured.
                    if (taken)
                        seq_err <= 1'b1;
                    if (tgt_halt) begin
                        state <= HALTED;
                    end else begin
                        pc    <= tgt;
                        state <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign delay_slot = (state == DELAY);
    assign fetch_en   = (state != HALTED);
    assign active     = (state != HALTED);

`ifdef PC_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
            br_count    <= '0;
        end else begin
            if (advance)
                instr_count <= instr_count + 32'd1;
            if (accept)
                br_count <= br_count + 32'd1;
        end
    end
`else
    assign instr_count = 32'h0;
    assign br_count    = 32'h0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model queues expected outputs per cycle.
module tb_pc_sequencer;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        fetch_en;
        logic        delay_slot;
        logic        active;
        logic        seq_err;
        logic [31:0] ic;
        logic [31:0] bc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, stall, br_valid, br_taken;
    logic [31:0] br_target;
    logic [31:0] pc, instr_count, br_count;
    logic        fetch_en, delay_slot, active, seq_err;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    // Reference model: fetch address plus an optional redirect waiting one fetch.
    logic [31:0] m_pc;
    bit          m_redirect_waiting;
    logic [31:0] m_redirect_to;
    bit          m_stopped;
    bit          m_err;
    logic [31:0] m_ic, m_bc;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid),
        .br_taken(br_taken), .br_target(br_target), .pc(pc), .fetch_en(fetch_en),
        .delay_slot(delay_slot), .active(active), .seq_err(seq_err),
        .instr_count(instr_count), .br_count(br_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model(input bit r, input bit s, input bit bv, input bit bt,
                                  input logic [31:0] t);
        if (r) begin
            m_pc = 32'hBFC0_0000;
            m_redirect_waiting = 0;
            m_stopped = 0;
            m_err = 0;
            m_ic = 0;
            m_bc = 0;
        end else if (!m_stopped && !s) begin
            m_ic = m_ic + 1;
            if (m_redirect_waiting) begin
                if (bv && bt) m_err = 1;
                m_redirect_waiting = 0;
                if (m_redirect_to == 32'h0) m_stopped = 1;
                else m_pc = m_redirect_to;
            end else begin
                m_pc = m_pc + 4;
                if (bv && bt) begin
                    if (t % 4 != 0) m_err = 1;
                    m_redirect_to = t - (t % 4);
                    m_redirect_waiting = 1;
                    m_bc = m_bc + 1;
                end
            end
        end
    endfunction

    task automatic step(input bit r, input bit s, input bit bv, input bit bt,
                        input logic [31:0] t);
        exp_t e;
        reset = r; stall = s; br_valid = bv; br_taken = bt; br_target = t;
        model(r, s, bv, bt, t);
        e.pc = m_pc;
        e.fetch_en = !m_stopped;
        e.active = !m_stopped;
        e.delay_slot = m_redirect_waiting;
        e.seq_err = m_err;
`ifdef PC_SEQ_PERF_EN
        e.ic = m_ic;
        e.bc = m_bc;
`else
        e.ic = 0;
        e.bc = 0;
`endif
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic nop(); step(0, 0, 0, 0, 32'h0); endtask
    task automatic rst(); step(1, 0, 0, 0, 32'h0); endtask
    task automatic br(input logic [31:0] t); step(0, 0, 1, 1, t); endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", pc, e.pc);
            chk("fetch_en", 32'(fetch_en), 32'(e.fetch_en));
            chk("active", 32'(active), 32'(e.active));
            chk("delay_slot", 32'(delay_slot), 32'(e.delay_slot));
            chk("seq_err", 32'(seq_err), 32'(e.seq_err));
            chk("instr_count", instr_count, e.ic);
            chk("br_count", br_count, e.bc);
        end
    end

    initial begin
        reset = 1; stall = 0; br_valid = 0; br_taken = 0; br_target = 0;
        // Sequential fetch, then a taken branch at BFC00008.
        rst(); nop(); nop();
        br(32'hBFC0_0100); nop(); nop();
        // Stall inside the delay slot with a branch pending on the bus.
        br(32'hBFC0_0200);
        repeat (3) step(0, 1, 1, 1, 32'hBFC0_0300);
        nop(); nop();
        // Misaligned target plus a branch in the delay slot.
        rst(); br(32'hBFC0_0102); br(32'hBFC0_0400); nop(); nop();
        // Reset in the middle of a delay slot, then count again.
        rst(); nop(); br(32'hBFC0_0500); rst(); nop(); br(32'hBFC0_0600); nop(); nop();
        // Wrap past the top of the address space is not a halt.
        rst(); br(32'hFFFF_FFF8); nop(); nop(); nop(); nop();
        // Jump to zero halts after the delay slot; everything else is ignored.
        rst(); nop(); br(32'h0000_0000); nop();
        repeat (10) step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                         32'hBFC0_0000 | ($urandom & 32'hFFF));
        rst(); nop();
        // Randomized traffic with occasional resets and halts.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] t;
            t = 32'hBFC0_0000 | ($urandom & 32'hFFC);
            if ($urandom_range(0, 7) == 0) t = t | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 63) == 0) t = 32'h0;
            if ($urandom_range(0, 31) == 0) t = 32'hFFFF_FFF0;
            step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, t);
        end
        step(0, 0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
